// File: rtl/axi4_burst_pkg.sv
// Shared constants, FSM encodings and helpers for the AXI4 burst memory slave.
package axi4_burst_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/axi4_burst_mem_slave_if.sv
// AXI4 write/read channel bundle between a master and the burst memory slave.
interface axi4_burst_mem_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     S_AXI_AWID;
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [7:0]          S_AXI_AWLEN;
    logic [2:0]          S_AXI_AWSIZE;
    logic [1:0]          S_AXI_AWBURST;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WLAST;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [ID_W-1:0]     S_AXI_BID;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ID_W-1:0]     S_AXI_ARID;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [7:0]          S_AXI_ARLEN;
    logic [2:0]          S_AXI_ARSIZE;
    logic [1:0]          S_AXI_ARBURST;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [ID_W-1:0]     S_AXI_RID;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RLAST;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next beat address (FIXED/INCR/WRAP) and whole-burst legality for one AXI channel.
module axi_burst_addr_gen
    import axi4_burst_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int MEM_DEPTH = 256
) (
    input  logic [ADDR_W-1:0] cur_addr,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              burst_err
);
    localparam int          OFFS      = clog2(DATA_W / 8);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * DATA_W / 8);

    logic [31:0] cur, bytes, wsize, wmask, lower, next32, last_beat;
    logic        len_ok;

    // burst_err is only meaningful while cur_addr holds the burst start address
    always_comb begin
        cur    = 32'(cur_addr);
        bytes  = 32'd1 << size;
        wsize  = (32'(len) + 32'd1) << size;
        wmask  = wsize - 32'd1;
        lower  = cur & ~wmask;
        case (burst)
            BURST_FIXED: begin
                next32    = cur;
                last_beat = cur;
            end
            BURST_WRAP: begin
                next32    = lower | ((cur + bytes) & wmask);
                last_beat = lower + wsize - bytes;
            end
            default: begin
                next32    = cur + bytes;
                last_beat = cur + (32'(len) << size);
            end
        endcase
        len_ok    = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        burst_err = (size != 3'(OFFS)) || (burst == 2'b11) ||
                    ((burst == BURST_WRAP) && (!len_ok || ((cur & (bytes - 32'd1)) != 32'd0))) ||
                    (last_beat >= MEM_BYTES);
    end

    assign next_addr = ADDR_W'(next32);

endmodule

// File: rtl/axi4_burst_mem_slave.sv
// Parametrised AXI4 slave memory with independent write and read burst engines.
module axi4_burst_mem_slave
    import axi4_burst_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_ID_WIDTH   = 4,
    parameter int MEM_DEPTH          = 256
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    axi4_burst_mem_slave_if.slave s_axi
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int IW    = C_S_AXI_ID_WIDTH;
    localparam int OFFS  = clog2(DW / 8);
    localparam int IDX_W = clog2(MEM_DEPTH);

    logic [DW-1:0] mem [MEM_DEPTH];

    wr_state_t w_state, w_next;
    logic [IW-1:0] w_id, bid_q;
    logic [AW-1:0] w_addr, wg_addr, wg_next;
    logic [7:0]    w_len, w_cnt, wg_len;
    logic [2:0]    w_size, wg_size;
    logic [1:0]    w_burst, wg_burst, bresp_q;
    logic          w_bad, w_err, wg_err, awready_q, wready_q, bvalid_q;
    logic          aw_hs, w_hs, b_hs, w_last_beat;
    logic [IDX_W-1:0] w_idx;

    assign aw_hs       = s_axi.S_AXI_AWVALID & awready_q;
    assign w_hs        = s_axi.S_AXI_WVALID & wready_q;
    assign b_hs        = bvalid_q & s_axi.S_AXI_BREADY;
    assign w_last_beat = (w_cnt == w_len);
    assign w_idx       = IDX_W'(w_addr >> OFFS);

    assign wg_addr  = (w_state == W_IDLE) ? s_axi.S_AXI_AWADDR  : w_addr;
    assign wg_len   = (w_state == W_IDLE) ? s_axi.S_AXI_AWLEN   : w_len;
    assign wg_size  = (w_state == W_IDLE) ? s_axi.S_AXI_AWSIZE  : w_size;
    assign wg_burst = (w_state == W_IDLE) ? s_axi.S_AXI_AWBURST : w_burst;

    axi_burst_addr_gen #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(MEM_DEPTH)) u_wr_gen (
        .cur_addr(wg_addr), .len(wg_len), .size(wg_size), .burst(wg_burst),
        .next_addr(wg_next), .burst_err(wg_err)
    );

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            w_state <= W_IDLE;
            awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0;
            bresp_q <= RESP_OKAY; bid_q <= '0; w_id <= '0;
            w_addr <= '0; w_len <= '0; w_cnt <= '0; w_size <= '0; w_burst <= '0;
            w_bad <= 1'b0; w_err <= 1'b0;
        end else begin
            w_state   <= w_next;
            awready_q <= (w_next == W_IDLE);
            wready_q  <= (w_next == W_DATA);
            bvalid_q  <= (w_next == W_RESP);
            if (aw_hs) begin
                w_id <= s_axi.S_AXI_AWID; w_addr <= s_axi.S_AXI_AWADDR; w_len <= s_axi.S_AXI_AWLEN;
                w_size <= s_axi.S_AXI_AWSIZE; w_burst <= s_axi.S_AXI_AWBURST;
                w_cnt <= '0; w_bad <= wg_err; w_err <= wg_err;
            end
            if (w_hs) begin
                w_addr <= wg_next;
                w_cnt  <= w_cnt + 8'd1;
                // WLAST never terminates the burst; a misplaced or missing WLAST only poisons BRESP
                if (s_axi.S_AXI_WLAST != w_last_beat) w_err <= 1'b1;
                if (w_last_beat) begin
                    bresp_q <= (w_err || !s_axi.S_AXI_WLAST) ? RESP_SLVERR : RESP_OKAY;
                    bid_q   <= w_id;
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (w_hs && !w_bad) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) mem[w_idx][b*8 +: 8] <= s_axi.S_AXI_WDATA[b*8 +: 8];
            end
        end
    end

    rd_state_t r_state, r_next;
    logic [IW-1:0] rid_q;
    logic [AW-1:0] r_addr, rg_addr, rg_next;
    logic [7:0]    r_len, r_cnt, rg_len;
    logic [2:0]    r_size, rg_size;
    logic [1:0]    r_burst, rg_burst, rresp_q;
    logic [DW-1:0] rdata_q;
    logic          r_bad, rg_err, arready_q, rvalid_q, rlast_q, ar_hs, r_hs;
    logic [IDX_W-1:0] rg_idx;

    assign ar_hs  = s_axi.S_AXI_ARVALID & arready_q;
    assign r_hs   = rvalid_q & s_axi.S_AXI_RREADY;
    assign rg_idx = IDX_W'(rg_addr >> OFFS);

    // r_addr always points at the beat to be presented after the current one
    assign rg_addr  = (r_state == R_IDLE) ? s_axi.S_AXI_ARADDR  : r_addr;
    assign rg_len   = (r_state == R_IDLE) ? s_axi.S_AXI_ARLEN   : r_len;
    assign rg_size  = (r_state == R_IDLE) ? s_axi.S_AXI_ARSIZE  : r_size;
    assign rg_burst = (r_state == R_IDLE) ? s_axi.S_AXI_ARBURST : r_burst;

    axi_burst_addr_gen #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(MEM_DEPTH)) u_rd_gen (
        .cur_addr(rg_addr), .len(rg_len), .size(rg_size), .burst(rg_burst),
        .next_addr(rg_next), .burst_err(rg_err)
    );

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && rlast_q) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state <= R_IDLE;
            arready_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
            rresp_q <= RESP_OKAY; rid_q <= '0; rdata_q <= '0;
            r_addr <= '0; r_len <= '0; r_cnt <= '0; r_size <= '0; r_burst <= '0; r_bad <= 1'b0;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
            if (ar_hs) begin
                rid_q <= s_axi.S_AXI_ARID; r_len <= s_axi.S_AXI_ARLEN;
                r_size <= s_axi.S_AXI_ARSIZE; r_burst <= s_axi.S_AXI_ARBURST;
                r_bad <= rg_err; r_addr <= rg_next; r_cnt <= '0;
                rvalid_q <= 1'b1;
                rlast_q  <= (s_axi.S_AXI_ARLEN == 8'd0);
                rdata_q  <= rg_err ? '0 : mem[rg_idx];
                rresp_q  <= rg_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_hs) begin
                if (rlast_q) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                end else begin
                    rdata_q <= r_bad ? '0 : mem[rg_idx];
                    r_addr  <= rg_next;
                    r_cnt   <= r_cnt + 8'd1;
                    rlast_q <= ((r_cnt + 8'd1) == r_len);
                end
            end
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_BID     = bid_q;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RLAST   = rlast_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RID     = rid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Scoreboard bench for axi4_burst_mem_slave: shadow memory model, queued read expectations.
module tb_axi4_burst_mem_slave;
    import axi4_burst_pkg::*;

    localparam int DW = 32, AW = 12, IW = 4, DEPTH = 256;

    logic tb_ACLK = 1'b0;
    logic tb_ARESET = 1'b1;
    always #5 tb_ACLK = ~tb_ACLK;

    axi4_burst_mem_slave_if #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) bus ();

    axi4_burst_mem_slave #(
        .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .C_S_AXI_ID_WIDTH(IW), .MEM_DEPTH(DEPTH)
    ) dut (
        .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESET(tb_ARESET), .s_axi(bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;

    rbeat_t      sb[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int beat_addr(input int a, input int len, input int size, input int burst, input int i);
        int nb, wsz, lower, cur;
        nb = 1 << size;
        wsz = (len + 1) * nb;
        lower = (a / wsz) * wsz;
        cur = a;
        for (int k = 0; k < i; k++) begin
            if (burst == 1) cur += nb;
            else if (burst == 2) begin
                cur += nb;
                if (cur >= lower + wsz) cur = lower;
            end
        end
        return cur;
    endfunction

    function automatic bit burst_bad(input int a, input int len, input int size, input int burst);
        bit bad;
        bad = (size != 2) || (burst == 3);
        if (burst == 2)
            bad = bad || !(len == 1 || len == 3 || len == 7 || len == 15) || ((a % (1 << size)) != 0);
        for (int i = 0; i <= len; i++)
            if (beat_addr(a, len, size, burst, i) >= DEPTH * 4) bad = 1'b1;
        return bad;
    endfunction

    task automatic do_write(input int id, input int a, input int len, input int size, input int burst,
                            input bit early_last, input int abort_at);
        bit bad;
        int t;
        logic [1:0] exp_resp;
        bad = burst_bad(a, len, size, burst);
        exp_resp = (bad || early_last) ? RESP_SLVERR : RESP_OKAY;
        bus.S_AXI_AWID = 4'(id); bus.S_AXI_AWADDR = 12'(a); bus.S_AXI_AWLEN = 8'(len);
        bus.S_AXI_AWSIZE = 3'(size); bus.S_AXI_AWBURST = 2'(burst); bus.S_AXI_AWVALID = 1'b1;
        t = 0;
        @(negedge tb_ACLK);
        while (!bus.S_AXI_AWREADY && t < 50) begin @(negedge tb_ACLK); t++; end
        if (t >= 50) check("aw_timeout", 64'(0), 64'(1));
        @(posedge tb_ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i == abort_at) begin
                tb_ARESET = 1'b1;
                #1;
                check("rst_awready", 64'(bus.S_AXI_AWREADY), 64'(0));
                check("rst_wready", 64'(bus.S_AXI_WREADY), 64'(0));
                check("rst_bvalid", 64'(bus.S_AXI_BVALID), 64'(0));
                bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
                return;
            end
            bus.S_AXI_WDATA = wd[i]; bus.S_AXI_WSTRB = ws[i];
            bus.S_AXI_WLAST = (i == len) || (early_last && i == 0);
            bus.S_AXI_WVALID = 1'b1;
            t = 0;
            @(negedge tb_ACLK);
            while (!bus.S_AXI_WREADY && t < 50) begin @(negedge tb_ACLK); t++; end
            if (t >= 50) check("w_timeout", 64'(0), 64'(1));
            @(posedge tb_ACLK); #1;
            if (!bad) begin
                int wa;
                wa = beat_addr(a, len, size, burst, i);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model_mem[wa / 4][b*8 +: 8] = wd[i][b*8 +: 8];
            end
        end
        bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        t = 0;
        @(negedge tb_ACLK);
        while (!bus.S_AXI_BVALID && t < 50) begin @(negedge tb_ACLK); t++; end
        if (t >= 50) check("b_timeout", 64'(0), 64'(1));
        check("bid", 64'(bus.S_AXI_BID), 64'(id));
        check("bresp", 64'(bus.S_AXI_BRESP), 64'(exp_resp));
        @(posedge tb_ACLK); #1;
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input int id, input int a, input int len, input int size, input int burst,
                           input bit stall);
        bit bad;
        int t;
        logic [3:0] pat;
        pat = 4'b1001;
        bad = burst_bad(a, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            rbeat_t e;
            int ba;
            ba = beat_addr(a, len, size, burst, i);
            if (bad) e.data = 32'h0;
            else e.data = model_mem[ba / 4];
            e.resp = bad ? RESP_SLVERR : RESP_OKAY;
            e.last = (i == len);
            e.id = 4'(id);
            sb.push_back(e);
        end
        bus.S_AXI_ARID = 4'(id); bus.S_AXI_ARADDR = 12'(a); bus.S_AXI_ARLEN = 8'(len);
        bus.S_AXI_ARSIZE = 3'(size); bus.S_AXI_ARBURST = 2'(burst); bus.S_AXI_ARVALID = 1'b1;
        t = 0;
        @(negedge tb_ACLK);
        while (!bus.S_AXI_ARREADY && t < 50) begin @(negedge tb_ACLK); t++; end
        if (t >= 50) check("ar_timeout", 64'(0), 64'(1));
        @(posedge tb_ACLK); #1;
        bus.S_AXI_ARVALID = 1'b0;
        t = 0;
        while (sb.size() > 0 && t < 200) begin
            bus.S_AXI_RREADY = stall ? pat[t % 4] : 1'b1;
            @(posedge tb_ACLK); #1;
            t++;
        end
        if (t >= 200) begin
            check("r_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
        bus.S_AXI_RREADY = 1'b0;
    endtask

    // Every presented beat is compared against the queue head; it is consumed only on handshake
    always @(negedge tb_ACLK) begin
        if (!tb_ARESET && bus.S_AXI_RVALID) begin
            if (sb.size() == 0) check("r_unexpected", 64'(1), 64'(0));
            else begin
                check("rdata", 64'(bus.S_AXI_RDATA), 64'(sb[0].data));
                check("rresp", 64'(bus.S_AXI_RRESP), 64'(sb[0].resp));
                check("rlast", 64'(bus.S_AXI_RLAST), 64'(sb[0].last));
                check("rid", 64'(bus.S_AXI_RID), 64'(sb[0].id));
                if (bus.S_AXI_RREADY) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWSIZE = '0;
        bus.S_AXI_AWBURST = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARSIZE = '0;
        bus.S_AXI_ARBURST = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        repeat (3) @(posedge tb_ACLK);
        #1;
        check("reset_awready", 64'(bus.S_AXI_AWREADY), 64'(0));
        check("reset_wready", 64'(bus.S_AXI_WREADY), 64'(0));
        check("reset_bvalid", 64'(bus.S_AXI_BVALID), 64'(0));
        check("reset_bresp", 64'(bus.S_AXI_BRESP), 64'(0));
        check("reset_bid", 64'(bus.S_AXI_BID), 64'(0));
        check("reset_arready", 64'(bus.S_AXI_ARREADY), 64'(0));
        check("reset_rvalid", 64'(bus.S_AXI_RVALID), 64'(0));
        check("reset_rlast", 64'(bus.S_AXI_RLAST), 64'(0));
        check("reset_rresp", 64'(bus.S_AXI_RRESP), 64'(0));
        check("reset_rid", 64'(bus.S_AXI_RID), 64'(0));
        check("reset_rdata", 64'(bus.S_AXI_RDATA), 64'(0));
        tb_ARESET = 1'b0;
        repeat (2) @(posedge tb_ACLK);
        #1;

        // 16-beat INCR write then read back, followed by a WRAP read inside it
        for (int i = 0; i < 16; i++) begin
            wd[i] = (i == 0) ? 32'h00abcdef : 32'(i) * 32'h11111111;
            ws[i] = 4'hF;
        end
        do_write(3, 12'h000, 15, 2, 1, 1'b0, -1);
        do_read(5, 12'h000, 15, 2, 1, 1'b0);
        do_read(6, 12'h008, 3, 2, 2, 1'b0);

        // FIXED burst keeps overwriting the same word
        for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
        do_write(1, 12'h020, 3, 2, 0, 1'b0, -1);
        do_read(2, 12'h020, 0, 2, 1, 1'b0);

        // Byte strobes
        wd[0] = 32'h11111111; ws[0] = 4'hF;
        do_write(4, 12'h040, 0, 2, 1, 1'b0, -1);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(4, 12'h040, 0, 2, 1, 1'b0, -1);
        do_read(4, 12'h040, 0, 2, 1, 1'b0);
        ws[0] = 4'hF; ws[1] = 4'hF;

        // Out-of-range burst must leave the in-range first word untouched
        wd[0] = 32'h5A5A5A5A;
        do_write(7, 12'h3FC, 0, 2, 1, 1'b0, -1);
        wd[0] = 32'hDEADBEEF; wd[1] = 32'hCAFEF00D;
        do_write(7, 12'h3FC, 1, 2, 1, 1'b0, -1);
        do_read(8, 12'h3FC, 1, 2, 1, 1'b0);
        do_read(8, 12'h3FC, 0, 2, 1, 1'b0);

        // Illegal size, burst type and wrap length
        wd[0] = 32'h12345678;
        do_write(9, 12'h060, 0, 1, 1, 1'b0, -1);
        do_read(10, 12'h000, 1, 2, 3, 1'b0);
        for (int i = 0; i < 3; i++) wd[i] = 32'hFFFF0000 + 32'(i);
        do_write(11, 12'h000, 2, 2, 2, 1'b0, -1);
        do_read(11, 12'h060, 0, 2, 1, 1'b0);

        // Early WLAST: data still lands, response is SLVERR
        wd[0] = 32'h01020304; wd[1] = 32'h05060708;
        do_write(12, 12'h080, 1, 2, 1, 1'b1, -1);
        do_read(12, 12'h080, 1, 2, 1, 1'b0);

        // Back-pressure on R with RREADY pattern 1-0-0-1
        do_read(13, 12'h000, 7, 2, 1, 1'b1);

        // Reset in the middle of a write burst, then recover
        for (int i = 0; i < 4; i++) wd[i] = 32'h0BAD0000 + 32'(i);
        do_write(14, 12'h100, 3, 2, 1, 1'b0, 2);
        repeat (2) @(posedge tb_ACLK);
        #1;
        tb_ARESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge tb_ACLK);
            check("post_rst_bvalid", 64'(bus.S_AXI_BVALID), 64'(0));
        end
        @(posedge tb_ACLK); #1;
        for (int i = 0; i < 4; i++) wd[i] = 32'hC0DE0000 + 32'(i * 7);
        do_write(15, 12'h100, 3, 2, 1, 1'b0, -1);
        do_read(15, 12'h100, 3, 2, 1, 1'b0);

        repeat (3) @(posedge tb_ACLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4_burst_mem_slave.md
Name: axi4_burst_mem_slave

Overview:
- Parametrised AXI4 (full) slave memory: the successor to the fixed 32-bit, 16-beat example slave in the myip2 IP.
- Adds configurable data width, depth and ID width; FIXED, INCR and WRAP bursts; WSTRB byte enables; ID echo; SLVERR on illegal accesses.
- Sits behind the interconnect as the matrix-operand buffer and is exercised by the AXI4 master BFM.

Parameters:
C_S_AXI_DATA_WIDTH  32  data bus width; legal values 32, 64, 128
C_S_AXI_ADDR_WIDTH  12  byte address width
C_S_AXI_ID_WIDTH  4  AXI ID width
MEM_DEPTH  256  memory words of DATA_WIDTH; must satisfy MEM_DEPTH*DATA_WIDTH/8 <= 2**ADDR_WIDTH

Ports:
S_AXI_ACLK  in  1  clock; all logic on rising edge
S_AXI_ARESET  in  1  asynchronous, active-high reset
S_AXI_AWID  in  ID_W  write ID
S_AXI_AWADDR  in  ADDR_W  write start byte address
S_AXI_AWLEN  in  8  beats-1
S_AXI_AWSIZE  in  3  log2 bytes/beat
S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
S_AXI_AWVALID  in  1  / S_AXI_AWREADY  out  1
S_AXI_WDATA  in  DATA_W / S_AXI_WSTRB  in  DATA_W/8
S_AXI_WLAST  in  1 / S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1
S_AXI_BID  out  ID_W / S_AXI_BRESP  out  2
S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1
S_AXI_ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID  in  (widths as AW) / S_AXI_ARREADY  out  1
S_AXI_RID  out  ID_W / S_AXI_RDATA  out  DATA_W / S_AXI_RRESP  out  2
S_AXI_RLAST  out  1 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1

Behaviour:
- Reset (async assert, sync-to-clock deassert path): all outputs 0 (AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST, BRESP, RRESP, IDs, RDATA); both FSMs to IDLE. Memory array is not cleared.
- Reset mid-burst: the burst is abandoned, no further beats, no B/R response.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1; on AWVALID latch ID/addr/len/size/burst, clear beat counter and error flag.
  - W_DATA: WREADY=1; each WVALID&WREADY writes the bytes enabled by WSTRB at the current word.
  - Last beat is beat count == AWLEN. WLAST is ignored for termination; WLAST on a non-final beat, or missing on the final beat, sets the error flag.
  - W_RESP: BVALID=1, BID=latched ID, BRESP=OKAY or SLVERR(10); held until BREADY.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1.
  - AR handshake at cycle N: RVALID=1 at N+1 carrying the first word (registered from a combinational array read).
  - While RVALID and !RREADY, RDATA/RRESP/RLAST are held stable.
  - On each handshake the next beat is presented the following cycle, so full throughput is 1 beat/cycle.
  - RLAST=1 on beat ARLEN; RID=latched ARID.
- Address generation (bytes B = 2**SIZE):
  - FIXED: address constant.
  - INCR: address += B.
  - WRAP: boundary = (LEN+1)*B aligned; on reaching the upper boundary, wrap to the lower boundary.
  - Word index = addr >> log2(DATA_W/8).
- Errors (SLVERR): SIZE != log2(DATA_W/8); BURST == 11; WRAP with LEN not in {1,3,7,15}; WRAP start not B-aligned; any beat address >= MEM_DEPTH*DATA_W/8.
  - Errored write beats: no memory update.
  - Errored read beats: RDATA=0, RRESP=SLVERR, but all LEN+1 beats are still returned.
- Channels are independent; one outstanding burst per direction.
- Same-cycle write and read to the same word: read returns the pre-write value.
- INCR crossing 4 KB is not checked (master responsibility).

Decomposition:
- Package axi4_burst_pkg: constants BURST_FIXED/INCR/WRAP, RESP_OKAY/EXOKAY/SLVERR, FSM state encodings, function clog2.
- Sub-module axi_burst_addr_gen (combinational next-address and wrap-boundary logic plus legality check), instantiated once for the write path and once for the read path.

Test Plan:
- INCR write, LEN=15, start 0x000, data 0x00abcdef, 0x11111111 ... 0xFFFFFFFF, then INCR read -> identical 16 words, BRESP=RRESP=OKAY, RLAST only on beat 15, RID=BID=written IDs.
- WRAP read LEN=3 from 0x008 after previous write -> words at 0x008, 0x00C, 0x000, 0x004, OKAY.
- FIXED write LEN=3 to 0x020 with data 1,2,3,4 -> read back 0x020 = 4.
- Partial strobes: write 0xAABBCCDD with WSTRB=0101 over 0x11111111 -> read 0x11BB11DD.
- Out-of-range INCR write/read at 0x3FC with LEN=1 (MEM_DEPTH=256) -> BRESP=SLVERR and no memory change; read returns RRESP=SLVERR with RDATA=0 on both beats. AWSIZE=1 -> SLVERR.
- RREADY toggled 1-0-0-1 mid-burst -> RDATA stable while stalled, no beat lost. ARESET asserted during W_DATA -> outputs 0 on the next edge, next AW accepted cleanly.
